nms_stream_lb: RTL and testbench
================================

# nms_stream_lb

Streaming non-maximum suppression stage for the Canny pipeline with built-in line buffers. It consumes a raster-order stream of packed {direction, squared-magnitude} gradient pixels and builds the 3x3 neighbourhood internally, so no external matrix generator is needed. It emits one thinned magnitude per input pixel, with border handling, a runtime compare mode, a magnitude floor, frame markers and an end-of-frame flush. It sits between the gradient/direction stage and the sqrt/double-threshold stages.

## Interface
- MAG_W, 24: magnitude width in bits.
- IMG_W, 640: pixels per row; must be at least 3.
- IMG_H, 512: rows per frame; must be at least 3.
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input pixel present.
- in_ready  out  1  block accepts a pixel; a pixel transfers when in_valid && in_ready.
- in_sof  in  1  qualifies an accepted pixel as frame pixel (0,0).
- in_data  in  MAG_W+2  {dir[1:0], mag[MAG_W-1:0]}.
- cfg_strict  in  1  compare mode, sampled per frame.
- cfg_floor  in  MAG_W  suppression floor, sampled per frame.
- out_valid  out  1  output pixel present. There is no backpressure; downstream always accepts.
- out_mag  out  MAG_W  thinned magnitude.
- out_sof, out_eol, out_eof  out  1 each  markers, valid only with out_valid.

## Operation
- **Position tracking**
  - Internal input position counters (row, col) are sized with $clog2(IMG_W) and $clog2(IMG_H).
  - The linear index of a pixel is k = row*IMG_W + col.
- **Line buffers**
  - Two IMG_W-deep line buffers plus 3x3 window registers.
  - The window centre is the pixel at input index k-(IMG_W+1).
- **States**
  - FILL: k < IMG_W+1. Pixels are accepted; no output is produced.
  - RUN: each accepted pixel produces one output, the centre pixel.
  - FLUSH: entered after the last pixel (k = IMG_W*IMG_H-1) is accepted. It emits the remaining IMG_W+1 centre pixels (all of them border pixels) with no input, one per cycle, then returns to FILL with the counters at 0.
- in_ready is 1 in FILL and RUN, and 0 in FLUSH.
- **Border pixels**
  - A border pixel is any pixel in row 0, row IMG_H-1, col 0 or col IMG_W-1.
  - Border pixels output 0.
  - Neighbours that wrap across rows are never used.
- **Direction pairs (a, b)**
  - 00: W / E.
  - 01: N / S.
  - 10: NW / SE.
  - 11: NE / SW.
- **Keep rule**
  - cfg_strict=0: keep when c >= a && c >= b.
  - cfg_strict=1: keep when c > a && c >= b. This breaks plateau ties deterministically.
  - Comparisons are unsigned over the MAG_W magnitude bits only.
  - The direction bits of neighbour pixels are ignored.
- **Floor**: if c < cfg_floor, the output is 0 even when the pixel is kept.
  - The kept output is the unchanged c.
- **Config sampling**: cfg_strict and cfg_floor are sampled when pixel (0,0) is accepted and held for the whole frame, including FLUSH.
- **Markers**
  - out_sof on output pixel (0,0).
  - out_eol on col IMG_W-1.
  - out_eof on pixel (IMG_H-1, IMG_W-1).
- **in_sof**
  - Accepted with in_sof=1 in FILL or RUN: the counters are forced so that this pixel is k=0, and the state becomes FILL.
  - Output of the abandoned frame stops; it is not flushed.
  - in_sof=1 on a pixel that is already at k=0 has no extra effect.
- **Mid-frame in_sof**: when in_sof truncates a frame, that frame's out_eof is never produced.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_mag=0.
  - All markers 0.
  - State FILL, counters 0, config registers 0.
  - Line-buffer contents are not cleared; they are don't-care because only border outputs depend on stale data.
- Latency:
  - The output for centre index j is registered one cycle after the acceptance of input index j+IMG_W+1.
  - Gaps in in_valid propagate as gaps in out_valid.
- Flush timing, with the last pixel accepted at cycle t:
  - Its output appears at t+1.
  - FLUSH occupies t+1 to t+IMG_W+1; flush outputs appear at t+2 to t+IMG_W+2.
  - in_ready returns high at t+IMG_W+2.
- Each frame yields exactly IMG_W*IMG_H outputs, in raster order.
- Reset asserted mid-frame or mid-flush: the next cycle shows reset values, and the partial frame is discarded.
- Throughput: 1 pixel per cycle in RUN. Per frame, IMG_W+1 stall cycles occur in FLUSH.

## Test plan
- **Strict ramp**: IMG_W=5, IMG_H=4, cfg_strict=0, cfg_floor=0; every pixel has dir=00 and mag=col*10. Expect 20 outputs. Borders are 0. Interior pixel (1,1) gives 0 because 10 < 20; (1,3) gives 0 because 30 < 40.
- **Ridge**: same sizes; column 2 has mag=100, all other pixels have mag=50, dir=00. Expect interior (r,2) = 100 and all other interior pixels 0. out_eol on every 5th output; out_sof and out_eof once each.
- **Plateau**: all pixels have mag=70, dir=01. With cfg_strict=0, all interior outputs are 70. With cfg_strict=1, all interior outputs are 0.
- **Floor and diagonals**: a centre of 40 with NW/SE neighbours of 30 and dir=10 outputs 40 when cfg_floor=40 and 0 when cfg_floor=41. Repeat with dir=11 and NE/SW neighbours of 50: output 0.
- **Flush and back-to-back frames**: two frames streamed with in_valid held high. Check that in_ready is low for exactly IMG_W+1 cycles after each last pixel, that the flush outputs are all 0, and that the second frame's out_sof follows the first frame's out_eof. Change cfg_floor mid-frame and check it has no effect until the next frame.
- **Resync and reset**: assert in_sof at k=7 and check that the counters restart and out_eof is never produced for the truncated frame. Pulse rst during FLUSH and check out_valid=0 and in_ready=1 on the next cycle.

Source files
------------

// File: rtl/nms_stream_lb.sv
`default_nettype none
// ============================================================================
// Module   : nms_stream_lb
// Purpose  : Streaming non-maximum suppression with internal line buffers.
//            Takes a raster stream of {dir, squared magnitude} pixels, builds
//            the 3x3 neighbourhood on the fly and emits one thinned magnitude
//            per input pixel. Border pixels output 0. After the last pixel of
//            a frame the remaining IMG_W+1 centres are flushed with no input.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            in_valid/in_ready    - input handshake
//            in_sof               - marks an accepted pixel as frame (0,0)
//            in_data              - {dir[1:0], mag[MAG_W-1:0]}
//            cfg_strict/cfg_floor - compare mode and floor, latched per frame
//            out_valid/out_mag    - thinned magnitude, no backpressure
//            out_sof/eol/eof      - raster markers of the output pixel
// Revision : 1.0 - initial release
// ============================================================================
module nms_stream_lb #(
  parameter int MAG_W = 24,
  parameter int IMG_W = 640,
  parameter int IMG_H = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [MAG_W+1:0] in_data,
  input  logic             cfg_strict,
  input  logic [MAG_W-1:0] cfg_floor,
  output logic             out_valid,
  output logic [MAG_W-1:0] out_mag,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_nx;

  // Input position and the position of the centre that is emitted next.
  logic [RW-1:0] row, crow;
  logic [CW-1:0] col, ccol;

  logic             strict_q;
  logic [MAG_W-1:0] floor_q;

  // lb1 holds the previous row (with direction, since the centre comes from
  // it); lb2 holds the row before that (magnitude only).
  logic [MAG_W+1:0] lb1 [IMG_W];
  logic [MAG_W-1:0] lb2 [IMG_W];

  // Two older window columns per row; the newest column is read straight
  // from the line buffers and the input so the result can be registered at
  // the acceptance edge.
  logic [MAG_W-1:0] top1, top2, mid1, bot1, bot2;
  logic [MAG_W+1:0] mid2;

  logic             accept, restart, emit, keep, border;
  logic [RW-1:0]    row_e;
  logic [CW-1:0]    col_e;
  logic [MAG_W-1:0] mag_in, ne, e_mag, a, b, c, mag_nx;
  logic [1:0]       dir_c;

  assign in_ready = (state != FLUSH);
  assign accept   = in_valid && in_ready;
  assign restart  = accept && in_sof;
  // in_sof forces the accepted pixel to position (0,0).
  assign row_e    = restart ? '0 : row;
  assign col_e    = restart ? '0 : col;

  assign mag_in = in_data[MAG_W-1:0];
  assign ne     = lb2[col_e];
  assign e_mag  = lb1[col_e][MAG_W-1:0];
  assign c      = mid2[MAG_W-1:0];
  assign dir_c  = mid2[MAG_W+1:MAG_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    emit     = 1'b0;
    case (state)
      FILL: begin
        // Pixel k = IMG_W is the last one that produces no output.
        if (accept && row_e == RW'(1) && col_e == '0) state_nx = RUN;
      end
      RUN: begin
        if (accept) begin
          if (restart) begin
            state_nx = FILL;
          end else begin
            emit = 1'b1;
            if (row_e == LAST_ROW && col_e == LAST_COL) state_nx = FLUSH;
          end
        end
      end
      FLUSH: begin
        emit = 1'b1;
        if (crow == LAST_ROW && ccol == LAST_COL) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  // Neighbour pair along the gradient direction.
  always_comb begin
    a = '0;
    b = '0;
    case (dir_c)
      2'b00:   begin a = mid1; b = e_mag;  end // W / E
      2'b01:   begin a = top2; b = bot2;   end // N / S
      2'b10:   begin a = top1; b = mag_in; end // NW / SE
      default: begin a = ne;   b = bot1;   end // NE / SW
    endcase
  end

  // The strict mode rejects ties against the first neighbour only, so a
  // plateau keeps at most one pixel along the direction.
  assign keep   = (strict_q ? (c > a) : (c >= a)) && (c >= b);
  // Any row-wrapped or stale neighbour only ever reaches a border centre.
  assign border = (crow == '0) || (crow == LAST_ROW) ||
                  (ccol == '0) || (ccol == LAST_COL);
  assign mag_nx = (border || !keep || (c < floor_q)) ? '0 : c;

  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      crow      <= '0;
      ccol      <= '0;
      strict_q  <= 1'b0;
      floor_q   <= '0;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      if (accept) begin
        if (col_e == LAST_COL) begin
          col <= '0;
          row <= (row_e == LAST_ROW) ? '0 : row_e + RW'(1);
        end else begin
          row <= row_e;
          col <= col_e + CW'(1);
        end
        if (row_e == '0 && col_e == '0) begin
          strict_q <= cfg_strict;
          floor_q  <= cfg_floor;
        end
      end

      if (restart) begin
        crow <= '0;
        ccol <= '0;
      end else if (emit) begin
        if (ccol == LAST_COL) begin
          ccol <= '0;
          crow <= (crow == LAST_ROW) ? '0 : crow + RW'(1);
        end else begin
          ccol <= ccol + CW'(1);
        end
      end

      out_valid <= emit;
      out_mag   <= emit ? mag_nx : '0;
      out_sof   <= emit && (crow == '0) && (ccol == '0);
      out_eol   <= emit && (ccol == LAST_COL);
      out_eof   <= emit && (crow == LAST_ROW) && (ccol == LAST_COL);
    end
  end

  // Line buffers and window: contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_e] <= in_data;
      lb2[col_e] <= lb1[col_e][MAG_W-1:0];
      top1       <= top2;
      top2       <= ne;
      mid1       <= mid2[MAG_W-1:0];
      mid2       <= lb1[col_e];
      bot1       <= bot2;
      bot2       <= mag_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nms_stream_lb.sv
`default_nettype none
// ============================================================================
// Module   : tb_nms_stream_lb
// Purpose  : Self-checking bench for nms_stream_lb (5x4 frames, 8-bit mags).
//            Expected outputs come from a 2-D reference model of the keep
//            rule and are queued per frame; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nms_stream_lb;

  localparam int MAG_W = 8;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int NPIX  = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, in_sof, cfg_strict;
  logic [MAG_W+1:0] in_data;
  logic [MAG_W-1:0] cfg_floor, out_mag;
  logic             out_valid, out_sof, out_eol, out_eof;

  nms_stream_lb #(.MAG_W(MAG_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_data(in_data), .cfg_strict(cfg_strict), .cfg_floor(cfg_floor),
    .out_valid(out_valid), .out_mag(out_mag),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [MAG_W-1:0] mag;
    logic             sof;
    logic             eol;
    logic             eof;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   fm [IMG_H][IMG_W];
  int   fd [IMG_H][IMG_W];

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: neighbour a sits at offset (dr,dc), b at the mirrored offset.
  function automatic int ref_pix(input int r, input int c, input bit strict, input int flr);
    int dr, dc, cv, av, bv;
    if (r == 0 || r == IMG_H-1 || c == 0 || c == IMG_W-1) return 0;
    case (fd[r][c])
      0:       begin dr =  0; dc = -1; end
      1:       begin dr = -1; dc =  0; end
      2:       begin dr = -1; dc = -1; end
      default: begin dr = -1; dc =  1; end
    endcase
    cv = fm[r][c];
    av = fm[r+dr][c+dc];
    bv = fm[r-dr][c-dc];
    if (strict ? (cv <= av) : (cv < av)) return 0;
    if (cv < bv || cv < flr) return 0;
    return cv;
  endfunction

  task automatic gen_frame(input int pattern);
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        case (pattern)
          0: begin fm[r][c] = c * 10;                          fd[r][c] = 0; end
          1: begin fm[r][c] = (c == 2) ? 100 : 50;             fd[r][c] = 0; end
          2: begin fm[r][c] = 70;                              fd[r][c] = 1; end
          3: begin fm[r][c] = (r == 1 && c == 2) ? 40 : 30;    fd[r][c] = 2; end
          4: begin fm[r][c] = (r == 1 && c == 2) ? 40 : 50;    fd[r][c] = 3; end
          default: begin
            fm[r][c] = int'($urandom_range(0, 15));
            fd[r][c] = int'($urandom_range(0, 3));
          end
        endcase
      end
    end
  endtask

  task automatic push_expected(input int n, input bit strict, input int flr);
    exp_t x;
    for (int j = 0; j < n; j++) begin
      x.mag = MAG_W'(ref_pix(j / IMG_W, j % IMG_W, strict, flr));
      x.sof = (j == 0);
      x.eol = ((j % IMG_W) == IMG_W-1);
      x.eof = (j == NPIX-1);
      sb.push_back(x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one pixel, waits for in_ready, and checks that an output is
  // registered at the acceptance edge exactly when k >= IMG_W+1.
  task automatic send_px(input int r, input int c, input bit sof, input int kidx,
                         output int stalls);
    stalls   = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = {2'(fd[r][c]), MAG_W'(fm[r][c])};
    while (!in_ready && stalls < 200) begin
      tick();
      stalls++;
    end
    if (stalls >= 200) check("in_ready_timeout", 0, 1);
    tick();
    check("out_valid_latency", int'(out_valid), int'(kidx >= IMG_W+1));
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic run_frame(input bit strict, input int flr, input int trunc_at,
                           input int flr_change_k, input bit gaps, input bit b2b);
    int lim, n_out, stalls;
    lim   = (trunc_at < 0) ? NPIX : trunc_at;
    n_out = (trunc_at < 0) ? NPIX :
            ((trunc_at > IMG_W+1) ? trunc_at - (IMG_W+1) : 0);
    push_expected(n_out, strict, flr);
    cfg_strict = strict;
    cfg_floor  = MAG_W'(flr);
    for (int k = 0; k < lim; k++) begin
      send_px(k / IMG_W, k % IMG_W, k == 0, k, stalls);
      if (k == 0 && b2b) check("flush_stall_cycles", stalls, IMG_W+1);
      if (k == flr_change_k) cfg_floor = MAG_W'(flr + 60);
      if (gaps && k < lim-1 && $urandom_range(0, 3) == 0) tick();
    end
  endtask

  // Monitor: every presented output must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_mag", int'(out_mag), int'(e.mag));
        check("markers_sof_eol_eof", int'({out_sof, out_eol, out_eof}),
              int'({e.sof, e.eol, e.eof}));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    cfg_strict = 1'b0; cfg_floor = '0;
    tick(); tick();
    check("reset_in_ready",  int'(in_ready),  1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_mag",   int'(out_mag),   0);
    check("reset_markers",   int'({out_sof, out_eol, out_eof}), 0);
    rst = 1'b0;
    tick();

    gen_frame(0); run_frame(1'b0, 0,  -1, -1, 1'b0, 1'b0);  // ramp
    gen_frame(1); run_frame(1'b0, 0,  -1, -1, 1'b0, 1'b1);  // ridge
    gen_frame(2); run_frame(1'b0, 0,  -1, -1, 1'b0, 1'b1);  // plateau
    gen_frame(2); run_frame(1'b1, 0,  -1, -1, 1'b0, 1'b1);  // plateau strict
    gen_frame(3); run_frame(1'b0, 40, -1,  3, 1'b0, 1'b1);  // floor 40, changed mid-frame
    gen_frame(3); run_frame(1'b0, 41, -1, -1, 1'b0, 1'b1);  // floor 41
    gen_frame(4); run_frame(1'b0, 0,  -1, -1, 1'b0, 1'b1);  // NE/SW diagonal
    gen_frame(5); run_frame(1'b0, 0,   7, -1, 1'b0, 1'b1);  // truncated by in_sof
    gen_frame(1); run_frame(1'b0, 0,  -1, -1, 1'b0, 1'b0);  // resync frame

    for (int i = 0; i < 8; i++) begin
      gen_frame(5);
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 8)), -1, -1,
                1'b1, 1'b0);
    end

    // Reset in the middle of FLUSH.
    gen_frame(5); run_frame(1'b0, 0, -1, -1, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("rst_flush_out_valid", int'(out_valid), 0);
    check("rst_flush_in_ready",  int'(in_ready),  1);

    gen_frame(5); run_frame(1'b1, 3, -1, -1, 1'b0, 1'b0);
    repeat (IMG_W + 8) tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
